pipeline_5_writeback: RTL and testbench

PIPELINE_5_WRITEBACK -- requirements
Module: pipeline_5_writeback

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/wb_load_fmt.sv | 38 +++
 rtl/pipeline_5_writeback.sv | 130 +++++++++++++
 tb/tb_pipeline_5_writeback.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the writeback stage.
//   - default widths/timeout for pipeline_5_writeback
//   - writeback FSM state encoding
//   - load-format (ld_mode) encodings
package pipeline_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_REG_ADDR_W  = 3;
  localparam int DEF_MEM_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_HOLD  = 2'd1,  // non-load captured, writes this cycle
    ST_LOAD  = 2'd2   // load captured, waiting on mem_valid
  } wb_state_t;

  typedef enum logic [1:0] {
    LD_WORD     = 2'b00,
    LD_BYTE_ZX  = 2'b01,
    LD_BYTE_SX  = 2'b10,
    LD_WORD_ALT = 2'b11   // behaves as a word load
  } ld_mode_t;

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load-data formatter.
//   mem_data : raw load response
//   ld_mode  : word / byte zero-extend / byte sign-extend
//   byte_sel : 0 low byte, 1 high byte (ignored when DATA_W <= 8)
//   fmt_data : formatted value, selected byte in [7:0]
module wb_load_fmt
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] mem_data,
  input  ld_mode_t          ld_mode,
  input  logic              byte_sel,
  output logic [DATA_W-1:0] fmt_data
);

  // Work in at least 16 bits so narrow widths can share the byte-select
  // logic; bits that do not exist in mem_data read as zero.
  localparam int EW = (DATA_W < 16) ? 16 : DATA_W;

  logic [EW-1:0] ext;
  logic [7:0]    byt;
  logic          sign;
  logic [EW-1:0] byte_ext;

  assign ext = EW'(mem_data);

  always_comb begin
    byt = ext[7:0];
    if (DATA_W > 8 && byte_sel) byt = ext[15:8];
  end

  assign sign     = (ld_mode == LD_BYTE_SX) & byt[7];
  assign byte_ext = {{(EW-8){sign}}, byt};
  assign fmt_data = (ld_mode == LD_BYTE_ZX || ld_mode == LD_BYTE_SX)
                  ? byte_ext[DATA_W-1:0] : mem_data;

endmodule

// File: rtl/pipeline_5_writeback.sv
// Pipeline writeback stage: captures one instruction, writes non-load
// results the next cycle, waits (bounded) on load data for loads.
// Optional macro WB_BYPASS_EN adds a one-cycle forwarding register.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready + in_* fields : upstream handshake and payload
//   mem_valid/mem_data              : load response (combinational use)
//   write/writenum/writeback_data   : register-file write port
//   busy, mem_err (sticky timeout)  : status
//   byp_valid/byp_num/byp_data      : previous-cycle write forwarding
module pipeline_5_writeback
  import pipeline_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wr_en,
  input  logic [REG_ADDR_W-1:0] in_wr_num,
  input  logic                  in_is_load,
  input  logic [1:0]            in_ld_mode,
  input  logic                  in_byte_sel,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  mem_valid,
  input  logic [DATA_W-1:0]     mem_data,
  output logic [DATA_W-1:0]     writeback_data,
  output logic [REG_ADDR_W-1:0] writenum,
  output logic                  write,
  output logic                  busy,
  output logic                  mem_err,
  output logic                  byp_valid,
  output logic [REG_ADDR_W-1:0] byp_num,
  output logic [DATA_W-1:0]     byp_data
);

  // Wait count that triggers the timeout: MEM_TIMEOUT low cycles in LOAD.
  localparam logic [7:0] TO_CNT = 8'(MEM_TIMEOUT - 1);

  wb_state_t             state;
  logic                  cap_wr_en;
  logic [REG_ADDR_W-1:0] cap_wr_num;
  ld_mode_t              cap_ld_mode;
  logic                  cap_byte_sel;
  logic [DATA_W-1:0]     cap_result;
  logic [7:0]            wait_cnt;
  logic                  mem_err_q;
  logic [DATA_W-1:0]     fmt_data;

  logic xfer, load_done, timeout;

  assign in_ready  = (state != ST_LOAD) | mem_valid;
  assign xfer      = in_valid & in_ready;
  assign load_done = (state == ST_LOAD) & mem_valid;
  assign timeout   = (state == ST_LOAD) & ~mem_valid & (wait_cnt == TO_CNT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_EMPTY;
      cap_wr_en    <= 1'b0;
      cap_wr_num   <= '0;
      cap_ld_mode  <= LD_WORD;
      cap_byte_sel <= 1'b0;
      cap_result   <= '0;
      wait_cnt     <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      if (timeout) mem_err_q <= 1'b1;

      if (xfer) begin
        cap_wr_en    <= in_wr_en;
        cap_wr_num   <= in_wr_num;
        cap_ld_mode  <= ld_mode_t'(in_ld_mode);
        cap_byte_sel <= in_byte_sel;
        cap_result   <= in_result;
        state        <= in_is_load ? ST_LOAD : ST_HOLD;
      end else if (state == ST_HOLD || load_done || timeout) begin
        state <= ST_EMPTY;
      end

      // xfer never coincides with a stalled LOAD, so the two are exclusive.
      if (xfer)                                wait_cnt <= '0;
      else if (state == ST_LOAD && !mem_valid) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  wb_load_fmt #(.DATA_W(DATA_W)) u_fmt (
    .mem_data (mem_data),
    .ld_mode  (cap_ld_mode),
    .byte_sel (cap_byte_sel),
    .fmt_data (fmt_data)
  );

  // Gated by rst so a mem_valid arriving in the reset cycle never writes.
  assign write          = rst & cap_wr_en & ((state == ST_HOLD) | load_done);
  assign writenum       = cap_wr_num;
  assign writeback_data = (state == ST_LOAD) ? fmt_data : cap_result;
  assign busy           = (state != ST_EMPTY);
  assign mem_err        = mem_err_q;

`ifdef WB_BYPASS_EN
  logic                  byp_valid_q;
  logic [REG_ADDR_W-1:0] byp_num_q;
  logic [DATA_W-1:0]     byp_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      byp_valid_q <= 1'b0;
      byp_num_q   <= '0;
      byp_data_q  <= '0;
    end else begin
      byp_valid_q <= write;
      byp_num_q   <= writenum;
      byp_data_q  <= writeback_data;
    end
  end

  assign byp_valid = byp_valid_q;
  assign byp_num   = byp_num_q;
  assign byp_data  = byp_data_q;
`else
  assign byp_valid = 1'b0;
  assign byp_num   = '0;
  assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_pipeline_5_writeback.sv
// Self-checking bench for pipeline_5_writeback (MEM_TIMEOUT = 4).
// Inputs are driven at the falling edge; outputs are checked 1 time unit
// later, i.e. in the same cycle, before the next rising edge.
module tb_pipeline_5_writeback;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wr_en, in_is_load, in_byte_sel;
  logic [2:0]  in_wr_num;
  logic [1:0]  in_ld_mode;
  logic [15:0] in_result;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic [15:0] writeback_data;
  logic [2:0]  writenum;
  logic        write, busy, mem_err;
  logic        byp_valid;
  logic [2:0]  byp_num;
  logic [15:0] byp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_5_writeback #(.DATA_W(16), .REG_ADDR_W(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wr_en(in_wr_en), .in_wr_num(in_wr_num), .in_is_load(in_is_load),
    .in_ld_mode(in_ld_mode), .in_byte_sel(in_byte_sel), .in_result(in_result),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .writeback_data(writeback_data), .writenum(writenum), .write(write),
    .busy(busy), .mem_err(mem_err),
    .byp_valid(byp_valid), .byp_num(byp_num), .byp_data(byp_data)
  );

  typedef struct {
    logic        iv, wen, isl, bsel, mv;
    logic [2:0]  wnum;
    logic [1:0]  mode;
    logic [15:0] res, md;
    logic        e_rdy, e_wr, e_busy, chk_d;
    logic [2:0]  e_num;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic iv, logic wen, logic [2:0] wnum, logic isl,
                              logic [1:0] mode, logic bsel, logic [15:0] res,
                              logic mv, logic [15:0] md, logic e_rdy, logic e_wr,
                              logic e_busy, logic chk_d, logic [2:0] e_num,
                              logic [15:0] e_data);
    vec_t v;
    v.iv = iv; v.wen = wen; v.wnum = wnum; v.isl = isl; v.mode = mode;
    v.bsel = bsel; v.res = res; v.mv = mv; v.md = md;
    v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_busy = e_busy; v.chk_d = chk_d;
    v.e_num = e_num; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic wen,
                       input logic [2:0] wnum, input logic isl, input logic [1:0] mode,
                       input logic bsel, input logic [15:0] res,
                       input logic mv, input logic [15:0] md);
    @(negedge clk);
    rst = r; in_valid = iv; in_wr_en = wen; in_wr_num = wnum; in_is_load = isl;
    in_ld_mode = mode; in_byte_sel = bsel; in_result = res;
    mem_valid = mv; mem_data = md;
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; in_wr_en = 0; in_wr_num = 0; in_is_load = 0;
    in_ld_mode = 0; in_byte_sel = 0; in_result = 0; mem_valid = 0; mem_data = 0;

    //            iv wen num isl mode bs res      mv md       rdy wr bsy cd num data
    vecs[0]  = mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
    vecs[1]  = mk(1, 1, 5, 0, 2'd0, 0, 16'h1234, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
    vecs[2]  = mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 1, 16'h9999, 1, 1, 1, 1, 5, 16'h1234);
    vecs[3]  = mk(1, 1, 3, 1, 2'd0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
    vecs[4]  = mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 1, 16'hBEEF, 1, 1, 1, 1, 3, 16'hBEEF);
    vecs[5]  = mk(1, 1, 6, 1, 2'd2, 1, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
    vecs[6]  = mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 0, 16'h80FF, 0, 0, 1, 0, 0, 16'h0000);
    vecs[7]  = mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 0, 16'h80FF, 0, 0, 1, 0, 0, 16'h0000);
    vecs[8]  = mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 0, 16'h80FF, 0, 0, 1, 0, 0, 16'h0000);
    vecs[9]  = mk(1, 1, 1, 0, 2'd0, 0, 16'h5555, 1, 16'h80FF, 1, 1, 1, 1, 6, 16'hFF80);
    vecs[10] = mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1, 1, 1, 16'h5555);
    vecs[11] = mk(1, 1, 2, 1, 2'd1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
    vecs[12] = mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 1, 16'h12C3, 1, 1, 1, 1, 2, 16'h00C3);
    vecs[13] = mk(1, 0, 4, 1, 2'd3, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
    vecs[14] = mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 1, 16'hABCD, 1, 0, 1, 1, 4, 16'hABCD);
    vecs[15] = mk(0, 0, 0, 0, 2'd0, 0, 16'h0000, 1, 16'h1111, 1, 0, 0, 0, 0, 16'h0000);

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(1, vecs[i].iv, vecs[i].wen, vecs[i].wnum, vecs[i].isl, vecs[i].mode,
            vecs[i].bsel, vecs[i].res, vecs[i].mv, vecs[i].md);
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d write", i),    32'(write),    32'(vecs[i].e_wr));
      chk($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].e_busy));
      chk($sformatf("v%0d mem_err", i),  32'(mem_err),  32'd0);
      if (vecs[i].chk_d) begin
        chk($sformatf("v%0d writenum", i), 32'(writenum),       32'(vecs[i].e_num));
        chk($sformatf("v%0d wb_data", i),  32'(writeback_data), 32'(vecs[i].e_data));
      end
      if (!BYP) chk($sformatf("v%0d byp_tied", i), {byp_valid, byp_num, byp_data}, 32'd0);
    end

    // Timeout: 4 low cycles in LOAD drop the load and set the sticky flag.
    drive(1, 1, 1, 7, 1, 2'd0, 0, 16'h0, 0, 16'h0);
    chk("to accept", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 0, 2'd0, 0, 16'h0, 0, 16'h0);
      chk($sformatf("to wait%0d write", k), 32'(write), 32'd0);
      chk($sformatf("to wait%0d ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("to wait%0d busy", k), 32'(busy), 32'd1);
      chk($sformatf("to wait%0d err", k), 32'(mem_err), 32'd0);
    end
    drive(1, 0, 0, 0, 0, 2'd0, 0, 16'h0, 1, 16'h1234);
    chk("to after busy", 32'(busy), 32'd0);
    chk("to after err", 32'(mem_err), 32'd1);
    chk("to after write", 32'(write), 32'd0);
    chk("to after ready", 32'(in_ready), 32'd1);
    drive(1, 1, 1, 1, 0, 2'd0, 0, 16'h0042, 0, 16'h0);
    chk("to sticky1", 32'(mem_err), 32'd1);
    drive(1, 0, 0, 0, 0, 2'd0, 0, 16'h0, 0, 16'h0);
    chk("to sticky2", 32'(mem_err), 32'd1);
    chk("post-to write", 32'(write), 32'd1);
    chk("post-to data", 32'(writeback_data), 32'h0042);
    drive(0, 0, 0, 0, 0, 2'd0, 0, 16'h0, 0, 16'h0);
    drive(1, 0, 0, 0, 0, 2'd0, 0, 16'h0, 0, 16'h0);
    chk("rst clears err", 32'(mem_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);

    // Reset mid-LOAD with mem_valid high: no write, idle afterwards.
    drive(1, 1, 1, 5, 1, 2'd0, 0, 16'h0, 0, 16'h0);
    drive(0, 0, 0, 0, 0, 2'd0, 0, 16'h0, 1, 16'h5A5A);
    chk("rst-load write", 32'(write), 32'd0);
    drive(1, 0, 0, 0, 0, 2'd0, 0, 16'h0, 1, 16'h5A5A);
    chk("rst-load busy", 32'(busy), 32'd0);
    chk("rst-load write2", 32'(write), 32'd0);
    chk("rst-load ready", 32'(in_ready), 32'd1);

    // Forwarding of a write to r2.
    drive(1, 1, 1, 2, 0, 2'd0, 0, 16'h00AA, 0, 16'h0);
    drive(1, 0, 0, 0, 0, 2'd0, 0, 16'h0, 0, 16'h0);
    chk("byp src write", 32'(write), 32'd1);
    chk("byp src num", 32'(writenum), 32'd2);
    drive(1, 0, 0, 0, 0, 2'd0, 0, 16'h0, 0, 16'h0);
    chk("byp valid", 32'(byp_valid), 32'(BYP));
    chk("byp num", 32'(byp_num), BYP ? 32'd2 : 32'd0);
    chk("byp data", 32'(byp_data), BYP ? 32'h00AA : 32'd0);
    drive(1, 0, 0, 0, 0, 2'd0, 0, 16'h0, 0, 16'h0);
    chk("byp one-cycle", 32'(byp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
